timed_seq_ctrl: RTL and testbench
=================================

# timed_seq_ctrl

Programmable playback controller for timed output sequences. Holds a small table of (data word, duration) entries written by a host, and on command plays them out on a data bus, each word held for its programmed number of ticks. Supports one-shot or looping playback, stop and pause. Drives the same kind of `out_data` bus the existing timed-sequence generator drives, and replaces its fixed pattern with a run-time-loaded one.

## Interface
- `MAIN_HZ`, 1_000_000, system clock frequency in Hz.
- `TICK_HZ`, 1_000, duration tick rate. `CPT = MAIN_HZ/TICK_HZ` clock cycles per tick; `CPT` must be ≥ 1.
- `DATA_BITS`, 8, width of the output word.
- `DUR_BITS`, 8, width of the duration field, in ticks.
- `ADDR_BITS`, 4, table address width. `DEPTH = 2**ADDR_BITS`.
- `IDLE_DATA`, '0, value of `out_data` when not playing.

Ports (name, direction, width, meaning):
- `in_clk`, in, 1, single system clock.
- `in_rst`, in, 1, reset; synchronous, active-low.
- `in_enable`, in, 1, tick enable. Low pauses playback (prescaler frozen); data is held.
- `in_wr`, in, 1, table write strobe.
- `in_wr_addr`, in, ADDR_BITS, table write address.
- `in_wr_data`, in, DATA_BITS, data word to write.
- `in_wr_dur`, in, DUR_BITS, duration to write, in ticks.
- `in_start`, in, 1, start playback; accepted only in IDLE.
- `in_stop`, in, 1, abort playback.
- `in_len`, in, ADDR_BITS+1, number of entries to play (1..DEPTH); sampled at start.
- `in_loop`, in, 1, loop mode; sampled at start.
- `out_data`, out, DATA_BITS, current sequence word.
- `out_busy`, out, 1, high while in RUN.
- `out_done`, out, 1, one-cycle pulse at natural end of a one-shot run.
- `out_idx`, out, ADDR_BITS, index of the entry currently playing.

## Operation
- Reset (`in_rst`=0 at a clock edge) puts the block in the following state:
  - state IDLE;
  - `out_data`=IDLE_DATA, `out_busy`=0, `out_done`=0, `out_idx`=0;
  - prescaler cleared.
  - Table contents are not reset.
- Table writes:
  - accepted in any state; `in_wr` writes both fields at `in_wr_addr`.
  - A write to the entry currently playing takes effect the next time that entry is loaded.
- States: IDLE and RUN.
- IDLE → RUN when `in_start`=1 and `1 ≤ in_len ≤ DEPTH`. On that transition:
  - latch `in_len` and `in_loop`;
  - `out_idx`=0 and `out_data`=data[0];
  - load `remain` with dur[0];
  - clear the prescaler.
  - `in_start` with an out-of-range `in_len` is ignored.
- RUN, on each tick:
  - if `remain`>1, decrement `remain`;
  - otherwise advance to the next entry:
    - if `idx < len-1`: `idx`+1, load that entry's data and duration;
    - else if loop mode: `idx`=0, load entry 0;
    - else: go to IDLE, `out_data`=IDLE_DATA, pulse `out_done`.
- Duration 0 is treated as 1 tick.
- `in_stop` in RUN:
  - next state is IDLE with `out_data`=IDLE_DATA and `out_idx`=0;
  - no `out_done` pulse.
  - `in_stop` has priority over a simultaneous tick.
  - `in_stop` in IDLE does nothing.
- `in_start` in RUN is ignored (no restart).
- `in_enable`=0 holds both the prescaler and `remain`; state and outputs are unchanged.

## Timing
- All outputs are registered.
- Start accepted at edge c:
  - `out_busy`=1 and `out_data`=data[0] are visible from cycle c+1.
- Prescaler:
  - counts 0..CPT-1 while enabled in RUN;
  - tick is the cycle with count = CPT-1.
- Entry k is visible for exactly max(dur[k],1)·CPT enabled cycles.
- The new word appears in the cycle after the terminating tick.
- `out_done` is high for exactly one cycle, coincident with the first IDLE cycle and `out_busy`=0.
- A new `in_start` is accepted in that same cycle.
- Stop at edge s: IDLE outputs are visible from s+1.
- Loop wrap has no gap: entry 0 follows the last entry with the same per-entry timing.

## Structure
- Package `timed_seq_pkg` contains:
  - `t_seq_state` enum {IDLE, RUN};
  - a function `cycles_per_tick(main_hz, tick_hz)`.
- Sub-module `tick_gen`:
  - inputs: clear, enable;
  - output: one-cycle tick every CPT enabled cycles.
- Table: register array of DEPTH × (DATA_BITS+DUR_BITS) with combinational read.

## Test plan
All scenarios use MAIN_HZ=1_000_000, TICK_HZ=250_000 (CPT=4), DATA_BITS=8.

1. **One-shot run:** table {0x11/d1, 0x22/d2, 0x33/d1}, `in_len`=3, `in_loop`=0, start at cycle 0.
   - `out_data`: 0x11 for cycles 1–4, 0x22 for 5–12, 0x33 for 13–16.
   - Cycle 17: 0x00 with `out_done`=1; cycle 18: `out_done`=0.
2. **Loop mode:** same table, `in_loop`=1.
   - After 0x33, `out_data`=0x11 at cycle 17; `out_done` never asserts; `out_idx` wraps 2→0.
3. **Stop mid-run:** `in_stop` at cycle 7 during 0x22.
   - Cycle 8: `out_data`=0x00, `out_busy`=0, no `out_done`.
   - A start at cycle 8 replays from 0x11.
4. **Pause:** `in_enable`=0 for 10 cycles during entry 0.
   - 0x11 is held 14 cycles in total; subsequent timing is shifted by 10.
5. **Edge cases:**
   - dur=0 entry lasts 4 cycles;
   - `in_len`=0 or `in_len`=17 (with ADDR_BITS=4): start ignored, `out_busy` stays 0;
   - `in_start` during RUN: no effect.
6. **Reset mid-run:** `in_rst`=0 at cycle 6.
   - Cycle 7: all outputs at reset values.
   - Table retained: a restart reproduces scenario 1.

Source files
------------

// File: rtl/timed_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timed_seq_pkg
//  Purpose  : Shared types and helpers for the timed sequence controller.
//             t_seq_state   - playback FSM states (IDLE, RUN)
//             cycles_per_tick - system clocks per duration tick
//  Revision : 1.0 - initial release
// ============================================================================
package timed_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } t_seq_state;

    // Integer division; callers must pick MAIN_HZ >= TICK_HZ so the result
    // is at least one clock per tick.
    function automatic int cycles_per_tick(input int main_hz, input int tick_hz);
        return main_hz / tick_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Purpose  : Prescaler producing a one-cycle tick every CPT enabled cycles.
//  Ports    : clk      - system clock
//             rst_n    - synchronous active-low reset (clears the count)
//             i_clear  - synchronous clear, dominates enable
//             i_enable - count enable; low freezes the count
//             o_tick   - high in the enabled cycle where count = CPT-1
//  Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int CPT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    // A one-bit counter is kept even for CPT = 1 so the logic stays legal;
    // in that case it simply sits at zero and every enabled cycle ticks.
    localparam int              c_cw   = (CPT > 1) ? $clog2(CPT) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(CPT - 1);

    logic [c_cw-1:0] r_cnt;
    logic            w_at_last;

    assign w_at_last = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_at_last ? '0 : r_cnt + c_cw'(1);
        end
    end

    assign o_tick = i_enable && !i_clear && w_at_last;

endmodule

`default_nettype wire

// File: rtl/timed_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : timed_seq_ctrl
//  Purpose  : Plays a host-loaded table of (data, duration) entries onto
//             out_data, each word held for max(dur,1) ticks; one-shot or
//             looping, with stop and pause.
//  Ports    : in_clk      - system clock
//             in_rst      - synchronous active-low reset
//             in_enable   - tick enable (low pauses, outputs held)
//             in_wr       - table write strobe
//             in_wr_addr  - table write address
//             in_wr_data  - data word to write
//             in_wr_dur   - duration (ticks) to write
//             in_start    - start playback (IDLE only, 1 <= in_len <= DEPTH)
//             in_stop     - abort playback
//             in_len      - number of entries to play, sampled at start
//             in_loop     - loop mode, sampled at start
//             out_data    - current sequence word (IDLE_DATA when idle)
//             out_busy    - high while playing
//             out_done    - one-cycle pulse at natural end of a one-shot run
//             out_idx     - index of the entry currently playing
//  Revision : 1.0 - initial release
// ============================================================================
module timed_seq_ctrl
    import timed_seq_pkg::*;
#(
    parameter int                   MAIN_HZ   = 1_000_000,
    parameter int                   TICK_HZ   = 1_000,
    parameter int                   DATA_BITS = 8,
    parameter int                   DUR_BITS  = 8,
    parameter int                   ADDR_BITS = 4,
    parameter logic [DATA_BITS-1:0] IDLE_DATA = '0
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    input  logic                 in_wr,
    input  logic [ADDR_BITS-1:0] in_wr_addr,
    input  logic [DATA_BITS-1:0] in_wr_data,
    input  logic [DUR_BITS-1:0]  in_wr_dur,
    input  logic                 in_start,
    input  logic                 in_stop,
    input  logic [ADDR_BITS:0]   in_len,
    input  logic                 in_loop,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [ADDR_BITS-1:0] out_idx
);

    localparam int               c_cpt     = cycles_per_tick(MAIN_HZ, TICK_HZ);
    localparam int               c_depth   = 2 ** ADDR_BITS;
    localparam int               c_ew      = DATA_BITS + DUR_BITS;
    localparam logic [ADDR_BITS:0] c_len_max = (ADDR_BITS + 1)'(c_depth);

    // ------------------------------------------------------------------
    // Entry table: {data, duration} per slot, not reset, read combinationally.
    // ------------------------------------------------------------------
    logic [c_ew-1:0] r_table [c_depth];

    always_ff @(posedge in_clk) begin
        if (in_wr) begin
            r_table[in_wr_addr] <= {in_wr_data, in_wr_dur};
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    t_seq_state           r_state,  w_state_nxt;
    logic [DATA_BITS-1:0] r_data,   w_data_nxt;
    logic [ADDR_BITS-1:0] r_idx,    w_idx_nxt;
    logic [DUR_BITS-1:0]  r_remain, w_remain_nxt;
    logic [ADDR_BITS:0]   r_len,    w_len_nxt;
    logic                 r_loop,   w_loop_nxt;
    logic                 r_done,   w_done_nxt;
    logic                 r_busy,   w_busy_nxt;

    logic                 w_tick;
    logic                 w_start_ok;
    logic [ADDR_BITS:0]   w_idx_inc;
    logic                 w_last;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic [c_ew-1:0]      w_rd_entry;
    logic [DATA_BITS-1:0] w_rd_data;
    logic [DUR_BITS-1:0]  w_rd_dur;

    // Prescaler is held cleared whenever we are not playing, so every run
    // (including one started on the done cycle) begins from count 0.
    tick_gen #(
        .CPT (c_cpt)
    ) u_tick_gen (
        .clk      (in_clk),
        .rst_n    (in_rst),
        .i_clear  (r_state != RUN),
        .i_enable (in_enable),
        .o_tick   (w_tick)
    );

    assign w_start_ok = in_start && (in_len != '0) && (in_len <= c_len_max);

    // Compare in ADDR_BITS+1 bits so len = DEPTH does not wrap.
    assign w_idx_inc  = {1'b0, r_idx} + (ADDR_BITS + 1)'(1);
    assign w_last     = (w_idx_inc >= r_len);

    // The only entry ever loaded is entry 0 (start, loop wrap) or idx+1.
    assign w_rd_addr  = (r_state == RUN && !w_last) ? w_idx_inc[ADDR_BITS-1:0] : '0;
    assign w_rd_entry = r_table[w_rd_addr];
    assign w_rd_data  = w_rd_entry[c_ew-1:DUR_BITS];
    assign w_rd_dur   = w_rd_entry[DUR_BITS-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_idx_nxt    = r_idx;
        w_remain_nxt = r_remain;
        w_len_nxt    = r_len;
        w_loop_nxt   = r_loop;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt  = RUN;
                    w_len_nxt    = in_len;
                    w_loop_nxt   = in_loop;
                    w_idx_nxt    = '0;
                    w_data_nxt   = w_rd_data;
                    w_remain_nxt = w_rd_dur;
                end
            end
            RUN: begin
                if (in_stop) begin
                    w_state_nxt = IDLE;
                    w_data_nxt  = IDLE_DATA;
                    w_idx_nxt   = '0;
                end else if (w_tick) begin
                    // remain of 0 or 1 both end the entry: duration 0 acts as 1.
                    if (r_remain > DUR_BITS'(1)) begin
                        w_remain_nxt = r_remain - DUR_BITS'(1);
                    end else if (!w_last || r_loop) begin
                        w_idx_nxt    = w_rd_addr;
                        w_data_nxt   = w_rd_data;
                        w_remain_nxt = w_rd_dur;
                    end else begin
                        w_state_nxt = IDLE;
                        w_data_nxt  = IDLE_DATA;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_data_nxt  = IDLE_DATA;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == RUN);

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            r_state  <= IDLE;
            r_data   <= IDLE_DATA;
            r_idx    <= '0;
            r_remain <= '0;
            r_len    <= '0;
            r_loop   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_idx    <= w_idx_nxt;
            r_remain <= w_remain_nxt;
            r_len    <= w_len_nxt;
            r_loop   <= w_loop_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign out_data = r_data;
    assign out_busy = r_busy;
    assign out_done = r_done;
    assign out_idx  = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_timed_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timed_seq_ctrl
//  Purpose  : Self-checking bench for timed_seq_ctrl (CPT = 4). Directed
//             scenarios with cycle-exact expectations, then randomized
//             traffic checked every cycle against an entry/elapsed-cycle
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timed_seq_ctrl;

    localparam int c_cpt = 4;

    logic       clk;
    logic       in_rst;
    logic       in_enable;
    logic       in_wr;
    logic [3:0] in_wr_addr;
    logic [7:0] in_wr_data;
    logic [7:0] in_wr_dur;
    logic       in_start;
    logic       in_stop;
    logic [4:0] in_len;
    logic       in_loop;
    logic [7:0] out_data;
    logic       out_busy;
    logic       out_done;
    logic [3:0] out_idx;

    timed_seq_ctrl #(
        .MAIN_HZ   (1_000_000),
        .TICK_HZ   (250_000),
        .DATA_BITS (8),
        .DUR_BITS  (8),
        .ADDR_BITS (4),
        .IDLE_DATA (8'h00)
    ) dut (
        .in_clk     (clk),
        .in_rst     (in_rst),
        .in_enable  (in_enable),
        .in_wr      (in_wr),
        .in_wr_addr (in_wr_addr),
        .in_wr_data (in_wr_data),
        .in_wr_dur  (in_wr_dur),
        .in_start   (in_start),
        .in_stop    (in_stop),
        .in_len     (in_len),
        .in_loop    (in_loop),
        .out_data   (out_data),
        .out_busy   (out_busy),
        .out_done   (out_done),
        .out_idx    (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: which entry is showing and how many enabled cycles
    // it has been shown, against its hold time in cycles.
    logic [7:0] m_tdata [16];
    logic [7:0] m_tdur  [16];
    logic       m_busy    = 1'b0;
    logic       m_done    = 1'b0;
    logic [7:0] m_data    = 8'h00;
    logic [3:0] m_idx     = 4'd0;
    int         m_len     = 0;
    logic       m_loop    = 1'b0;
    int         m_hold    = 0;
    int         m_elapsed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_load(input int k);
        m_idx     = 4'(k);
        m_data    = m_tdata[k];
        m_hold    = ((m_tdur[k] == 8'd0) ? 1 : int'(m_tdur[k])) * c_cpt;
        m_elapsed = 0;
    endtask

    // Advance the model over the coming clock edge using the current inputs.
    task automatic model_step();
        if (!in_rst) begin
            m_busy = 1'b0;
            m_data = 8'h00;
            m_done = 1'b0;
            m_idx  = 4'd0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (in_stop) begin
                    m_busy = 1'b0;
                    m_data = 8'h00;
                    m_idx  = 4'd0;
                end else if (in_enable) begin
                    m_elapsed++;
                    if (m_elapsed >= m_hold) begin
                        if (int'(m_idx) + 1 < m_len) begin
                            m_load(int'(m_idx) + 1);
                        end else if (m_loop) begin
                            m_load(0);
                        end else begin
                            m_busy = 1'b0;
                            m_data = 8'h00;
                            m_idx  = 4'd0;
                            m_done = 1'b1;
                        end
                    end
                end
            end else if (in_start && in_len >= 5'd1 && in_len <= 5'd16) begin
                m_len  = int'(in_len);
                m_loop = in_loop;
                m_busy = 1'b1;
                m_load(0);
            end
        end
        // Loads above saw the table as it was before this edge.
        if (in_wr) begin
            m_tdata[in_wr_addr] = in_wr_data;
            m_tdur[in_wr_addr]  = in_wr_dur;
        end
    endtask

    // One clock: model and DUT step together, outputs checked #1 later.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("data", 32'(out_data), 32'(m_data));
        chk("busy", 32'(out_busy), 32'(m_busy));
        chk("done", 32'(out_done), 32'(m_done));
        chk("idx",  32'(out_idx),  32'(m_idx));
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] du);
        in_wr      = 1'b1;
        in_wr_addr = a;
        in_wr_data = d;
        in_wr_dur  = du;
        cyc();
        in_wr      = 1'b0;
    endtask

    // Scenario 1 timeline: 0x11 cycles 1-4, 0x22 5-12, 0x33 13-16, done at 17.
    task automatic run_s1(input string tag);
        logic [7:0] exp;
        in_len   = 5'd3;
        in_loop  = 1'b0;
        in_start = 1'b1;
        cyc();
        in_start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            exp = (c <= 4) ? 8'h11 : (c <= 12) ? 8'h22 : (c <= 16) ? 8'h33 : 8'h00;
            chk({tag, "_data"}, 32'(out_data), 32'(exp));
            chk({tag, "_done"}, 32'(out_done), 32'(c == 17));
            chk({tag, "_busy"}, 32'(out_busy), 32'(c <= 16));
            if (c < 18) cyc();
        end
    endtask

    initial begin
        int held;
        in_rst     = 1'b0;
        in_enable  = 1'b1;
        in_wr      = 1'b0;
        in_wr_addr = 4'd0;
        in_wr_data = 8'h00;
        in_wr_dur  = 8'h00;
        in_start   = 1'b0;
        in_stop    = 1'b0;
        in_len     = 5'd0;
        in_loop    = 1'b0;

        repeat (3) cyc();
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_busy", 32'(out_busy), 32'h0);
        chk("rst_done", 32'(out_done), 32'h0);
        chk("rst_idx",  32'(out_idx),  32'h0);
        in_rst = 1'b1;

        for (int a = 3; a < 16; a++) wr(4'(a), 8'(8'h40 + a), 8'(a % 3));
        wr(4'd0, 8'h11, 8'd1);
        wr(4'd1, 8'h22, 8'd2);
        wr(4'd2, 8'h33, 8'd1);
        cyc();

        // 1: one-shot
        run_s1("s1");

        // 2: loop mode
        in_loop  = 1'b1;
        in_start = 1'b1;
        cyc();
        in_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 16) chk("s2_idx_last", 32'(out_idx), 32'd2);
            if (c == 17) begin
                chk("s2_wrap_data", 32'(out_data), 32'h11);
                chk("s2_wrap_idx",  32'(out_idx),  32'd0);
            end
            chk("s2_nodone", 32'(out_done), 32'd0);
            cyc();
        end
        in_stop = 1'b1;
        cyc();
        in_stop = 1'b0;
        in_loop = 1'b0;
        cyc();

        // 3: stop mid-run, restart, start ignored while running
        in_start = 1'b1;
        cyc();
        in_start = 1'b0;
        repeat (6) cyc();
        in_stop = 1'b1;
        cyc();
        in_stop = 1'b0;
        chk("s3_stop_data", 32'(out_data), 32'h00);
        chk("s3_stop_busy", 32'(out_busy), 32'd0);
        chk("s3_stop_done", 32'(out_done), 32'd0);
        in_start = 1'b1;
        cyc();
        chk("s3_restart", 32'(out_data), 32'h11);
        cyc();
        in_start = 1'b0;
        repeat (3) cyc();
        chk("s3_norestart", 32'(out_data), 32'h22);
        repeat (15) cyc();

        // 4: pause during entry 0
        in_start = 1'b1;
        cyc();
        in_start  = 1'b0;
        in_enable = 1'b0;
        repeat (10) cyc();
        in_enable = 1'b1;
        held = 10;
        while (out_data == 8'h11 && held < 40) begin
            held++;
            cyc();
        end
        chk("s4_hold", 32'(held), 32'd14);
        chk("s4_next", 32'(out_data), 32'h22);
        repeat (20) cyc();

        // 5: zero duration, out-of-range length
        wr(4'd0, 8'hA5, 8'd0);
        in_len   = 5'd1;
        in_start = 1'b1;
        cyc();
        in_start = 1'b0;
        held = 0;
        while (out_data == 8'hA5 && held < 40) begin
            held++;
            cyc();
        end
        chk("s5_dur0", 32'(held), 32'd4);
        chk("s5_done", 32'(out_done), 32'd1);
        wr(4'd0, 8'h11, 8'd1);
        in_len   = 5'd0;
        in_start = 1'b1;
        cyc();
        chk("s5_len0", 32'(out_busy), 32'd0);
        in_len = 5'd17;
        cyc();
        chk("s5_len17", 32'(out_busy), 32'd0);
        in_start = 1'b0;
        cyc();

        // 6: reset mid-run, table retained
        in_len   = 5'd3;
        in_start = 1'b1;
        cyc();
        in_start = 1'b0;
        repeat (5) cyc();
        in_rst = 1'b0;
        cyc();
        in_rst = 1'b1;
        chk("s6_data", 32'(out_data), 32'h00);
        chk("s6_busy", 32'(out_busy), 32'd0);
        chk("s6_done", 32'(out_done), 32'd0);
        chk("s6_idx",  32'(out_idx),  32'd0);
        cyc();
        run_s1("s6_replay");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_wr      = ($urandom % 8) == 0;
            in_wr_addr = 4'($urandom_range(0, 3));
            in_wr_data = 8'($urandom);
            in_wr_dur  = 8'($urandom_range(0, 3));
            in_start   = ($urandom % 6) == 0;
            in_len     = (($urandom % 10) == 0) ? 5'($urandom_range(0, 17))
                                                : 5'($urandom_range(1, 4));
            in_loop    = 1'($urandom);
            in_enable  = ($urandom % 10) != 0;
            in_stop    = ($urandom % 40) == 0;
            in_rst     = ($urandom % 500) != 0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
